// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
// Holds the register-index width, FSM state encodings and the ID/EX bubble value.
package pipeline_hazard_controller_pkg;

    localparam int REGISTER_INDEX_WIDTH = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Control fields that a flushed ID/EX register must carry so the bubble is harmless.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } id_ex_ctrl_t;

    function automatic id_ex_ctrl_t id_ex_bubble();
        id_ex_ctrl_t bubble;
        bubble.reg_write  = 1'b0;
        bubble.mem_to_reg = 1'b0;
        return bubble;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave):
// hazard-relevant pipeline status in, stall/flush controls and the stall counter out.
interface pipeline_hazard_controller_if #(
    parameter int REGISTER_INDEX_WIDTH = pipeline_hazard_controller_pkg::REGISTER_INDEX_WIDTH,
    parameter int COUNTER_WIDTH        = 32
);

    logic [REGISTER_INDEX_WIDTH-1:0] id_rs1;
    logic [REGISTER_INDEX_WIDTH-1:0] id_rs2;
    logic                            id_uses_rs1;
    logic                            id_uses_rs2;
    logic [REGISTER_INDEX_WIDTH-1:0] ex_destination_register;
    logic                            ex_mem_to_reg;
    logic                            ex_reg_write;
    logic                            ex_is_mul;
    logic                            ex_branch_taken;
    logic                            mem_cache_miss;

    logic                            if_stall;
    logic                            id_stall;
    logic                            ex_stall;
    logic                            if_id_flush;
    logic                            id_ex_flush;
    logic                            mul_busy;
    logic [COUNTER_WIDTH-1:0]        stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_destination_register, ex_mem_to_reg, ex_reg_write,
               ex_is_mul, ex_branch_taken, mem_cache_miss,
        input  if_stall, id_stall, ex_stall, if_id_flush, id_ex_flush,
               mul_busy, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_destination_register, ex_mem_to_reg, ex_reg_write,
               ex_is_mul, ex_branch_taken, mem_cache_miss,
        output if_stall, id_stall, ex_stall, if_id_flush, id_ex_flush,
               mul_busy, stall_cycles
    );

endinterface

// File: rtl/pipeline_hazard_controller_hazard_detector.sv
// Combinational load-use detector: a load in EX whose destination is read by ID.
// Kept standalone so a forwarding unit can reuse the same compare.
module pipeline_hazard_controller_hazard_detector #(
    parameter int REGISTER_INDEX_WIDTH = pipeline_hazard_controller_pkg::REGISTER_INDEX_WIDTH
) (
    input  logic [REGISTER_INDEX_WIDTH-1:0] id_rs1,
    input  logic [REGISTER_INDEX_WIDTH-1:0] id_rs2,
    input  logic                            id_uses_rs1,
    input  logic                            id_uses_rs2,
    input  logic [REGISTER_INDEX_WIDTH-1:0] ex_destination_register,
    input  logic                            ex_mem_to_reg,
    input  logic                            ex_reg_write,
    output logic                            load_use
);

    logic ex_loads_reg;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hard-wired to zero, so a load targeting it can never feed a consumer.
    assign ex_loads_reg = ex_mem_to_reg && ex_reg_write && (ex_destination_register != '0);
    assign rs1_hit      = id_uses_rs1 && (id_rs1 == ex_destination_register);
    assign rs2_hit      = id_uses_rs2 && (id_rs2 == ex_destination_register);
    assign load_use     = ex_loads_reg && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the in-order pipeline: cache-miss freeze, multi-cycle
// multiply occupancy of EX, load-use bubbles and taken-branch flushes, plus a stall counter.
module pipeline_hazard_controller #(
    parameter int REGISTER_INDEX_WIDTH = pipeline_hazard_controller_pkg::REGISTER_INDEX_WIDTH,
    parameter int MUL_LATENCY          = 4,
    parameter int COUNTER_WIDTH        = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    pipeline_hazard_controller_if.slave bus
);

    import pipeline_hazard_controller_pkg::state_t;
    import pipeline_hazard_controller_pkg::RUN;
    import pipeline_hazard_controller_pkg::MUL_WAIT;
    import pipeline_hazard_controller_pkg::MEM_WAIT;

    // Last value mul_count reaches; the cycle that reaches it is the final stall cycle.
    localparam logic [3:0] MUL_LAST = 4'(MUL_LATENCY - 1);

    state_t                   state;
    logic [3:0]               mul_count;
    logic                     mul_done;
    logic                     mul_return;
    logic [COUNTER_WIDTH-1:0] stall_cycles;

    logic                     load_use;
    logic                     miss_active;
    logic                     mul_start;
    logic                     mul_active;
    logic [3:0]               mul_count_next;

    logic                     if_stall;
    logic                     id_stall;
    logic                     ex_stall;
    logic                     if_id_flush;
    logic                     id_ex_flush;
    logic                     mul_busy;

    pipeline_hazard_controller_hazard_detector #(
        .REGISTER_INDEX_WIDTH(REGISTER_INDEX_WIDTH)
    ) u_hazard_detector (
        .id_rs1                 (bus.id_rs1),
        .id_rs2                 (bus.id_rs2),
        .id_uses_rs1            (bus.id_uses_rs1),
        .id_uses_rs2            (bus.id_uses_rs2),
        .ex_destination_register(bus.ex_destination_register),
        .ex_mem_to_reg          (bus.ex_mem_to_reg),
        .ex_reg_write           (bus.ex_reg_write),
        .load_use               (load_use)
    );

    always_comb begin
        miss_active    = bus.mem_cache_miss || (state == MEM_WAIT);
        mul_start      = (state == RUN) && bus.ex_is_mul && !mul_done;
        mul_active     = (state == MUL_WAIT) || mul_start;
        mul_count_next = mul_count + 4'd1;
    end

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        if_stall    = 1'b0;
        id_stall    = 1'b0;
        ex_stall    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        mul_busy    = 1'b0;
        if (!rst) begin
            if (miss_active || mul_active) begin
                if_stall = 1'b1;
                id_stall = 1'b1;
                ex_stall = 1'b1;
            end else if (bus.ex_branch_taken) begin
                // The ID instruction is squashed, so a coincident load-use needs no stall.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                if_stall    = 1'b1;
                id_stall    = 1'b1;
                id_ex_flush = 1'b1;
            end
            mul_busy = (state == MUL_WAIT)
                    || ((state == MEM_WAIT) && mul_return)
                    || (mul_start && !bus.mem_cache_miss);
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            mul_count    <= 4'd0;
            mul_done     <= 1'b0;
            mul_return   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (if_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + COUNTER_WIDTH'(1);
            end
            // Once EX advances the finished multiply has left, so a new one may start.
            if (!ex_stall) begin
                mul_done <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (bus.mem_cache_miss) begin
                        state      <= MEM_WAIT;
                        mul_return <= 1'b0;
                    end else if (mul_start) begin
                        if (mul_count_next == MUL_LAST) begin
                            state     <= RUN;
                            mul_count <= 4'd0;
                            mul_done  <= 1'b1;
                        end else begin
                            state     <= MUL_WAIT;
                            mul_count <= mul_count_next;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (bus.mem_cache_miss) begin
                        state      <= MEM_WAIT;
                        mul_return <= 1'b1;
                    end else if (mul_count_next == MUL_LAST) begin
                        state     <= RUN;
                        mul_count <= 4'd0;
                        mul_done  <= 1'b1;
                    end else begin
                        mul_count <= mul_count_next;
                    end
                end
                MEM_WAIT: begin
                    if (!bus.mem_cache_miss) begin
                        state <= mul_return ? MUL_WAIT : RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.if_stall     = if_stall;
    assign bus.id_stall     = id_stall;
    assign bus.ex_stall     = ex_stall;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.mul_busy     = mul_busy;
    assign bus.stall_cycles = stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a behavioural model checks every cycle,
// and hand-computed literals pin load-use, multiply, miss, branch, reset and saturation cases.
module tb_pipeline_hazard_controller;

    localparam int MUL_LAT = 4;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       load;
        logic       wr;
        logic       mul;
        logic       br;
        logic       miss;
    } vec_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    pipeline_hazard_controller_if #(.REGISTER_INDEX_WIDTH(5), .COUNTER_WIDTH(32)) bus ();
    pipeline_hazard_controller_if #(.REGISTER_INDEX_WIDTH(5), .COUNTER_WIDTH(4))  bus4 ();

    pipeline_hazard_controller #(
        .REGISTER_INDEX_WIDTH(5), .MUL_LATENCY(MUL_LAT), .COUNTER_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    pipeline_hazard_controller #(
        .REGISTER_INDEX_WIDTH(5), .MUL_LATENCY(MUL_LAT), .COUNTER_WIDTH(4)
    ) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packed view of the controls: {if_stall, id_stall, ex_stall, if_id_flush, id_ex_flush, mul_busy}.
    function automatic logic [5:0] outs();
        return {bus.if_stall, bus.id_stall, bus.ex_stall, bus.if_id_flush, bus.id_ex_flush, bus.mul_busy};
    endfunction

    // ---------------- behavioural model and per-cycle compare ----------------
    int      m_mul_left  = 0;   // multiply stall cycles still owed
    bit      m_retired   = 1'b0;
    bit      m_prev_miss = 1'b0;
    longint  m_cnt       = 0;
    logic    c_frozen, c_starting, c_stall_all, c_lu, c_br;
    logic [5:0] c_exp;

    always @(negedge clk) begin
        c_lu = bus.ex_mem_to_reg && bus.ex_reg_write && (bus.ex_destination_register != 5'd0)
            && ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_destination_register)
             || (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_destination_register));
        c_br        = bus.ex_branch_taken;
        c_frozen    = bus.mem_cache_miss || m_prev_miss;
        c_starting  = !c_frozen && (m_mul_left == 0) && bus.ex_is_mul && !m_retired;
        c_stall_all = c_frozen || (m_mul_left > 0) || c_starting;
        if (rst) begin
            c_exp = 6'b000000;
        end else begin
            c_exp[5] = c_stall_all || (c_lu && !c_br);
            c_exp[4] = c_exp[5];
            c_exp[3] = c_stall_all;
            c_exp[2] = !c_stall_all && c_br;
            c_exp[1] = !c_stall_all && (c_br || c_lu);
            c_exp[0] = (m_mul_left > 0) || c_starting;
        end
        check("cmp_ctrl", 64'(outs()), 64'(c_exp));
        check("cmp_cnt", 64'(bus.stall_cycles), 64'(m_cnt));
        // Advance the model across the coming rising edge.
        if (rst) begin
            m_mul_left  = 0;
            m_retired   = 1'b0;
            m_prev_miss = 1'b0;
            m_cnt       = 0;
        end else begin
            if (c_exp[5] && m_cnt != 64'hFFFF_FFFF) m_cnt++;
            if (!c_frozen) begin
                if (c_starting) m_mul_left = MUL_LAT - 1;
                if (m_mul_left > 0) begin
                    m_mul_left--;
                    if (m_mul_left == 0) m_retired = 1'b1;
                end
            end
            if (!c_stall_all) m_retired = 1'b0;
            m_prev_miss = bus.mem_cache_miss;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input vec_t v);
        rst                          = v.rst;
        bus.id_rs1                   = v.rs1;
        bus.id_rs2                   = v.rs2;
        bus.id_uses_rs1              = v.use1;
        bus.id_uses_rs2              = v.use2;
        bus.ex_destination_register  = v.rd;
        bus.ex_mem_to_reg            = v.load;
        bus.ex_reg_write             = v.wr;
        bus.ex_is_mul                = v.mul;
        bus.ex_branch_taken          = v.br;
        bus.mem_cache_miss           = v.miss;
        bus4.id_rs1                  = v.rs1;
        bus4.id_rs2                  = v.rs2;
        bus4.id_uses_rs1             = v.use1;
        bus4.id_uses_rs2             = v.use2;
        bus4.ex_destination_register = v.rd;
        bus4.ex_mem_to_reg           = v.load;
        bus4.ex_reg_write            = v.wr;
        bus4.ex_is_mul               = v.mul;
        bus4.ex_branch_taken         = v.br;
        bus4.mem_cache_miss          = v.miss;
    endtask

    // Drive just after a rising edge, return just after the following falling edge.
    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        #1;
    endtask

    function automatic vec_t ld(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
        vec_t v = '0;
        v.rd = rd; v.rs1 = rs1; v.use1 = u1; v.rs2 = rs2; v.use2 = u2;
        v.load = 1'b1; v.wr = 1'b1;
        return v;
    endfunction

    initial begin
        vec_t v_nop, v_rst, v, v_mul, v_mul_miss, v_br, v_br_miss, v_miss;
        v_nop = '0;
        v_rst = '0; v_rst.rst = 1'b1;
        v_mul = '0; v_mul.mul = 1'b1;
        v_mul_miss = v_mul; v_mul_miss.miss = 1'b1;
        v_br = '0; v_br.br = 1'b1;
        v_br_miss = v_br; v_br_miss.miss = 1'b1;
        v_miss = '0; v_miss.miss = 1'b1;

        drive(v_rst);
        apply(v_rst);
        apply(v_rst);
        check("reset_outs", 64'(outs()), 64'(6'b000000));
        check("reset_cnt", 64'(bus.stall_cycles), 64'd0);

        // Load to x5 consumed via rs2: one bubble cycle, then normal flow.
        apply(ld(5'd5, 5'd3, 1'b1, 5'd5, 1'b1));
        check("lu_rs2_stall", 64'(outs()), 64'(6'b110010));
        v = v_nop; v.rs1 = 5'd3; v.use1 = 1'b1; v.rs2 = 5'd5; v.use2 = 1'b1;
        apply(v);
        check("lu_release", 64'(outs()), 64'(6'b000000));
        check("lu_cnt", 64'(bus.stall_cycles), 64'd1);
        apply(ld(5'd0, 5'd0, 1'b1, 5'd0, 1'b1));
        check("x0_no_stall", 64'(outs()), 64'(6'b000000));
        apply(ld(5'd7, 5'd7, 1'b0, 5'd2, 1'b1));
        check("unused_rs1", 64'(outs()), 64'(6'b000000));
        apply(ld(5'd7, 5'd7, 1'b1, 5'd2, 1'b1));
        check("lu_rs1_stall", 64'(outs()), 64'(6'b110010));
        apply(v_nop);

        // Plain multiply: three stall cycles, released on the fourth.
        for (int i = 0; i < 3; i++) begin
            apply(v_mul);
            check("mul_stall", 64'(outs()), 64'(6'b111001));
        end
        apply(v_mul);
        check("mul_release", 64'(outs()), 64'(6'b000000));
        check("mul_cnt", 64'(bus.stall_cycles), 64'd5);
        apply(v_nop);

        // Miss held 5 cycles from the second multiply cycle; multiply then resumes.
        apply(v_mul);
        for (int i = 0; i < 5; i++) begin
            apply(v_mul_miss);
            check("miss_hold", 64'(outs()), 64'(6'b111001));
        end
        apply(v_mul);
        check("miss_tail", 64'(outs()), 64'(6'b111001));
        apply(v_mul);
        check("mul_resume", 64'(outs()), 64'(6'b111001));
        apply(v_mul);
        check("mul_last", 64'(outs()), 64'(6'b111001));
        apply(v_mul);
        check("mul2_release", 64'(outs()), 64'(6'b000000));
        check("mul2_cnt", 64'(bus.stall_cycles), 64'd14);
        apply(v_nop);

        // Taken branch, alone and behind a cache miss.
        apply(v_br);
        check("br_flush", 64'(outs()), 64'(6'b000110));
        apply(v_nop);
        check("br_once", 64'(outs()), 64'(6'b000000));
        apply(v_br_miss);
        check("br_miss_hold", 64'(outs()), 64'(6'b111000));
        apply(v_br);
        check("br_miss_tail", 64'(outs()), 64'(6'b111000));
        apply(v_br);
        check("br_after_miss", 64'(outs()), 64'(6'b000110));
        check("br_miss_cnt", 64'(bus.stall_cycles), 64'd16);
        apply(v_nop);

        // Load-use coinciding with a taken branch: flush only.
        v = ld(5'd5, 5'd3, 1'b1, 5'd5, 1'b1); v.br = 1'b1;
        apply(v);
        check("lu_with_br", 64'(outs()), 64'(6'b000110));
        apply(v_nop);

        // Reset in the middle of a multiply.
        apply(v_mul);
        apply(v_mul);
        check("rst_pre_mul", 64'(outs()), 64'(6'b111001));
        v = v_mul; v.rst = 1'b1;
        apply(v);
        check("rst_outs", 64'(outs()), 64'(6'b000000));
        apply(v);
        check("rst_outs2", 64'(outs()), 64'(6'b000000));
        check("rst_cnt", 64'(bus.stall_cycles), 64'd0);
        apply(v_nop);
        check("post_rst", 64'(outs()), 64'(6'b000000));
        check("post_rst_cnt", 64'(bus.stall_cycles), 64'd0);

        // 20 miss cycles plus the release cycle: the 4-bit counter must stop at 15.
        for (int i = 1; i <= 20; i++) begin
            apply(v_miss);
            if (i == 15) check("sat_14", 64'(bus4.stall_cycles), 64'd14);
            if (i == 16) check("sat_15", 64'(bus4.stall_cycles), 64'd15);
            if (i == 20) check("sat_hold", 64'(bus4.stall_cycles), 64'd15);
        end
        apply(v_nop);
        apply(v_nop);
        check("sat_final", 64'(bus4.stall_cycles), 64'd15);
        check("cnt_21", 64'(bus.stall_cycles), 64'd21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
